// File: rtl/timer_a_counter_pkg.sv
// ---------------------------------------------------------------------------
// timer_a_counter_pkg
//   Shared definitions for the Timer_A counter slice:
//     - default register addresses (TAxCTL, TAxR, TAxEX0)
//     - mode-control (MC) encodings
//     - TAxCTL / TAxEX0 bit positions
//     - helper that turns the ID/IDEX fields into a total tick divide factor
// ---------------------------------------------------------------------------
package timer_a_counter_pkg;

    // Default register addresses
    localparam logic [15:0] TAXCTL_ADDR = 16'h0340;
    localparam logic [15:0] TAXR_ADDR   = 16'h0350;
    localparam logic [15:0] TAXEX0_ADDR = 16'h0360;

    // Mode control encodings (TAxCTL.MC)
    typedef enum logic [1:0] {
        MC_STOP   = 2'b00,
        MC_UP     = 2'b01,
        MC_CONT   = 2'b10,
        MC_UPDOWN = 2'b11
    } mc_e;

    // TAxCTL bit positions
    localparam int unsigned CTL_TASSEL_LSB = 8;   // [9:8]
    localparam int unsigned CTL_ID_LSB     = 6;   // [7:6]
    localparam int unsigned CTL_MC_LSB     = 4;   // [5:4]
    localparam int unsigned CTL_TACLR_BIT  = 2;
    localparam int unsigned CTL_TAIE_BIT   = 1;
    localparam int unsigned CTL_TAIFG_BIT  = 0;

    // TAxEX0 bit positions
    localparam int unsigned EX0_IDEX_LSB   = 0;   // [2:0]

    // Total number of TimerTick pulses per count enable: (2**ID) * (IDEX+1),
    // range 1..64, so 7 bits are needed.
    function automatic logic [6:0] prescale_factor(input logic [1:0] id,
                                                   input logic [2:0] idex);
        logic [6:0] base;
        base = {4'b0000, idex} + 7'd1;
        return base << id;
    endfunction

endpackage

// File: rtl/timer_a_counter_prescaler.sv
// ---------------------------------------------------------------------------
// timer_a_prescaler
//   Counts TimerTick pulses and emits a one-cycle count enable every
//   (2**ID)*(IDEX+1) ticks. With a divide factor of 1 every tick is an enable.
//
//   Ports:
//     MCLK      in   clock, rising edge
//     reset     in   synchronous active-high reset
//     clear     in   synchronous restart of the tick count (TACLR)
//     TimerTick in   one-MCLK-wide tick (already gated off when stopped)
//     ID        in   input divider select, /1 /2 /4 /8
//     IDEX      in   expansion divider, /(IDEX+1)
//     CountEn   out  one-cycle count enable
// ---------------------------------------------------------------------------
module timer_a_prescaler
    import timer_a_counter_pkg::*;
(
    input  logic       MCLK,
    input  logic       reset,
    input  logic       clear,
    input  logic       TimerTick,
    input  logic [1:0] ID,
    input  logic [2:0] IDEX,
    output logic       CountEn
);

    logic [5:0] r_cnt;
    logic [6:0] w_factor;
    logic       w_last;

    assign w_factor = prescale_factor(ID, IDEX);

    // ">=" rather than "==" so that lowering the divider while the count is
    // above the new limit still produces an enable on the next tick.
    assign w_last = (({1'b0, r_cnt} + 7'd1) >= w_factor);

    assign CountEn = TimerTick && w_last && !clear && !reset;

    always_ff @(posedge MCLK) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (TimerTick) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/timer_a_counter.sv
// ---------------------------------------------------------------------------
// timer_a_counter
//   Timer_A main counter (TAxR) with control (TAxCTL) and expansion (TAxEX0)
//   registers, prescaler, overflow flag generation and CPU read mux.
//
//   Ports:
//     MCLK        in   16-bit bus clock, rising edge
//     reset       in   synchronous active-high reset
//     MAB         in   memory address bus
//     MDBwrite    in   write data
//     MW          in   write strobe
//     BW          in   byte write (low byte only)
//     TimerTick   in   one-cycle pulse per selected timer source edge
//     TAxCCR0     in   CCR0 value from capture/compare module 0
//     TAIFGclr    in   one-cycle flag clear from the interrupt vector logic
//     TAxRcurrent out  counter value
//     EQU0        out  counter equals CCR0 while running
//     TAIFG       out  overflow flag
//     TAIE        out  overflow interrupt enable
//     TASSEL      out  timer source select
//     MDBread     out  read data (0 when not addressed or during a write)
// ---------------------------------------------------------------------------
module timer_a_counter
    import timer_a_counter_pkg::*;
#(
    parameter logic [15:0] TAxCTL = TAXCTL_ADDR,
    parameter logic [15:0] TAxR   = TAXR_ADDR,
    parameter logic [15:0] TAxEX0 = TAXEX0_ADDR
)
(
    input  logic        MCLK,
    input  logic        reset,
    input  logic [15:0] MAB,
    input  logic [15:0] MDBwrite,
    input  logic        MW,
    input  logic        BW,
    input  logic        TimerTick,
    input  logic [15:0] TAxCCR0,
    input  logic        TAIFGclr,
    output logic [15:0] TAxRcurrent,
    output logic        EQU0,
    output logic        TAIFG,
    output logic        TAIE,
    output logic [1:0]  TASSEL,
    output logic [15:0] MDBread
);

    // Register state
    logic [1:0]  r_tassel;
    logic [1:0]  r_id;
    mc_e         r_mc;
    logic        r_taie;
    logic        r_taifg;
    logic [2:0]  r_idex;
    logic [15:0] r_tar;
    logic        r_dir_down;

    // Decode
    logic        w_wr_ctl;
    logic        w_wr_tar;
    logic        w_wr_ex0;
    logic        w_taclr;

    // Counting
    logic        w_tick_run;
    logic        w_cnt_en;
    logic        w_count;
    logic [15:0] w_tar_next;
    logic        w_dir_next;
    logic        w_hw_set;

    // Read path
    logic [15:0] w_ctl_rd;
    logic [15:0] w_rdata;

    assign w_wr_ctl = MW && (MAB == TAxCTL);
    assign w_wr_tar = MW && (MAB == TAxR);
    assign w_wr_ex0 = MW && (MAB == TAxEX0);
    assign w_taclr  = w_wr_ctl && MDBwrite[CTL_TACLR_BIT];

    // Ticks are dropped while stopped so the prescaler holds its count.
    assign w_tick_run = TimerTick && (r_mc != MC_STOP);

    timer_a_prescaler u_prescaler (
        .MCLK      (MCLK),
        .reset     (reset),
        .clear     (w_taclr),
        .TimerTick (w_tick_run),
        .ID        (r_id),
        .IDEX      (r_idex),
        .CountEn   (w_cnt_en)
    );

    // A CPU write to TAxR swallows a coincident count enable, including any
    // overflow flag that enable would have raised.
    assign w_count = w_cnt_en && !w_wr_tar;

    // -----------------------------------------------------------------------
    // Next counter value, direction and hardware flag set
    // -----------------------------------------------------------------------
    always_comb begin
        w_tar_next = r_tar;
        w_dir_next = r_dir_down;
        w_hw_set   = 1'b0;
        if (w_count) begin
            case (r_mc)
                MC_UP: begin
                    if (r_tar >= TAxCCR0) begin
                        w_tar_next = '0;
                        // CCR0=0 parks the counter at 0 without flagging.
                        w_hw_set   = (r_tar == TAxCCR0) && (TAxCCR0 != '0);
                    end else begin
                        w_tar_next = r_tar + 16'd1;
                    end
                end
                MC_CONT: begin
                    w_tar_next = r_tar + 16'd1;
                    w_hw_set   = (r_tar == 16'hFFFF);
                end
                MC_UPDOWN: begin
                    if (TAxCCR0 == '0) begin
                        w_tar_next = '0;
                        w_dir_next = 1'b0;
                    end else if (!r_dir_down) begin
                        if (r_tar >= TAxCCR0) begin
                            // Turnaround at (or beyond) CCR0. With CCR0=1 this
                            // step is itself the 1->0 transition.
                            w_tar_next = r_tar - 16'd1;
                            w_dir_next = 1'b1;
                            w_hw_set   = (r_tar == 16'd1);
                        end else begin
                            w_tar_next = r_tar + 16'd1;
                        end
                    end else begin
                        if (r_tar == '0) begin
                            w_tar_next = 16'd1;
                            w_dir_next = 1'b0;
                        end else begin
                            w_tar_next = r_tar - 16'd1;
                            if (r_tar == 16'd1) begin
                                w_hw_set   = 1'b1;
                                w_dir_next = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Counter and direction
    // -----------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_tar      <= '0;
            r_dir_down <= 1'b0;
        end else if (w_wr_tar) begin
            r_tar <= BW ? {r_tar[15:8], MDBwrite[7:0]} : MDBwrite;
        end else if (w_taclr) begin
            r_tar      <= '0;
            r_dir_down <= 1'b0;
        end else begin
            r_tar      <= w_tar_next;
            r_dir_down <= w_dir_next;
        end
    end

    // -----------------------------------------------------------------------
    // Control fields (TACLR is not stored: it acts only in its write cycle)
    // -----------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_tassel <= '0;
            r_id     <= '0;
            r_mc     <= MC_STOP;
            r_taie   <= 1'b0;
        end else if (w_wr_ctl) begin
            if (!BW) begin
                r_tassel <= MDBwrite[CTL_TASSEL_LSB +: 2];
            end
            r_id   <= MDBwrite[CTL_ID_LSB +: 2];
            r_mc   <= mc_e'(MDBwrite[CTL_MC_LSB +: 2]);
            r_taie <= MDBwrite[CTL_TAIE_BIT];
        end
    end

    // Flag priority: hardware set > TAIFGclr > software write.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_taifg <= 1'b0;
        end else if (w_hw_set) begin
            r_taifg <= 1'b1;
        end else if (TAIFGclr) begin
            r_taifg <= 1'b0;
        end else if (w_wr_ctl) begin
            r_taifg <= MDBwrite[CTL_TAIFG_BIT];
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_idex <= '0;
        end else if (w_wr_ex0) begin
            r_idex <= MDBwrite[EX0_IDEX_LSB +: 3];
        end
    end

    // -----------------------------------------------------------------------
    // Read mux
    // -----------------------------------------------------------------------
    always_comb begin
        w_ctl_rd                          = '0;
        w_ctl_rd[CTL_TASSEL_LSB +: 2]     = r_tassel;
        w_ctl_rd[CTL_ID_LSB +: 2]         = r_id;
        w_ctl_rd[CTL_MC_LSB +: 2]         = r_mc;
        w_ctl_rd[CTL_TAIE_BIT]            = r_taie;
        w_ctl_rd[CTL_TAIFG_BIT]           = r_taifg;
    end

    always_comb begin
        w_rdata = '0;
        if (!MW) begin
            if (MAB == TAxCTL) begin
                w_rdata = w_ctl_rd;
            end else if (MAB == TAxR) begin
                w_rdata = r_tar;
            end else if (MAB == TAxEX0) begin
                w_rdata = {13'b0, r_idex};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign TAxRcurrent = r_tar;
    assign EQU0        = (r_tar == TAxCCR0) && (r_mc != MC_STOP);
    assign TAIFG       = r_taifg;
    assign TAIE        = r_taie;
    assign TASSEL      = r_tassel;
    assign MDBread     = w_rdata;

endmodule
